spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_gen.sv | 46 ++++
 rtl/spi_master.sv | 158 +++++++++++++++
 tb/tb_spi_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default word geometry and the bus mode,
// used by the master and by the slave-side block.
package spi_pkg;

  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_BIT_CNT_WIDTH = 4;

  // Mode 0: sck idles low, data sampled on the rising edge.
  localparam logic       SPI_CPOL = 1'b0;
  localparam logic       SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  function automatic logic frame_closed(input spi_state_e s);
    return (s == ST_IDLE) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: a CLK_DIV-cycle down-counter whose terminal count
// paces every FSM phase and, while sck_en is high, toggles sck and emits rise/fall strobes.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic sck_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sck
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = run && (cnt == 8'd0);
  assign rise = tick && sck_en && !sck;
  assign fall = tick && sck_en && sck;

  // Counter is parked at RELOAD while stopped so the first phase is always a full CLK_DIV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
      sck <= SPI_CPOL;
    end else if (!run) begin
      cnt <= RELOAD;
      sck <= SPI_CPOL;
    end else begin
      if (cnt == 8'd0) begin
        cnt <= RELOAD;
      end else begin
        cnt <= cnt - 8'd1;
      end
      if (rise || fall) begin
        sck <= ~sck;
      end
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one DATA_WIDTH word per start, MSB first, framed by active-low ss.
// Optional back-to-back framing is enabled with the SPI_MASTER_BURST_EN macro.
//
// state | meaning
// IDLE  | ss high, waiting for start
// SETUP | ss low, mosi holds first bit, sck low for CLK_DIV cycles
// XFER  | sck toggles every CLK_DIV cycles, 2*DATA_WIDTH half-periods
// HOLD  | ss low after the last falling edge, sck low for CLK_DIV cycles
// GAP   | ss high, still busy for CLK_DIV cycles so the slave re-arms
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int BIT_CNT_WIDTH = DEF_BIT_CNT_WIDTH,
  parameter int CLK_DIV       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  new_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  ss,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  logic rst_meta;
  logic rst_n;

  // Assert immediately, release two clk edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  spi_state_e state;
  spi_state_e state_nxt;

  logic [DATA_WIDTH-1:0]    shift_q;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic                     run;
  logic                     sck_en;
  logic                     tick;
  logic                     rise;
  logic                     fall;
  logic                     load;
  logic                     finish;
  logic                     last_fall;

  assign run       = (state != ST_IDLE);
  assign sck_en    = (state == ST_XFER);
  assign busy      = (state != ST_IDLE);
  assign ss        = frame_closed(state);
  assign last_fall = fall && (bit_cnt == '0);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .sck_en (sck_en),
    .tick   (tick),
    .rise   (rise),
    .fall   (fall),
    .sck    (sck)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETUP;
          load      = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (last_fall) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          finish = 1'b1;
`ifdef SPI_MASTER_BURST_EN
          if (start) begin
            state_nxt = ST_SETUP;
            load      = 1'b1;
          end else begin
            state_nxt = ST_GAP;
          end
`else
          state_nxt = ST_GAP;
`endif
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // The counter wraps to zero on the last rising edge, which marks the closing falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      mosi     <= 1'b0;
      dout     <= '0;
      new_data <= 1'b0;
    end else begin
      new_data <= finish;
      if (finish) begin
        dout <= shift_q;
      end
      if (load) begin
        shift_q <= din;
        mosi    <= din[DATA_WIDTH-1];
        bit_cnt <= '0;
      end else if (rise) begin
        shift_q <= {shift_q[DATA_WIDTH-2:0], miso};
        bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
      end else if (fall && !last_fall) begin
        mosi <= shift_q[DATA_WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: cycle-level timing model plus a behavioural mode-0 slave.
module tb_spi_master;

  localparam int DW     = 16;
  localparam int C      = 4;
  localparam int T_XFER = 34 * C;
  localparam int T_BUSY = 35 * C;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] din   = '0;
  logic          miso;
  logic          busy, new_data, ss, sck, mosi;
  logic [DW-1:0] dout;

  spi_master #(.DATA_WIDTH(DW), .BIT_CNT_WIDTH(4), .CLK_DIV(C)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .busy(busy), .new_data(new_data),
    .dout(dout), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural mode-0 slave and bus monitors
  logic          loop_mode = 1'b1;
  logic [DW-1:0] slave_tx  = '0;
  logic [DW-1:0] s_sh = '0, s_rx = '0, slave_got = '0;
  logic          s_miso = 1'b0;
  int            rise_cnt = 0, rise_seen = 0, ss_fall = 0;
  time           t_rise = 0, t_mosi = 0;

  assign miso = loop_mode ? mosi : s_miso;

  always @(negedge ss) begin
    ss_fall++;
    s_sh   = slave_tx;
    s_miso = slave_tx[DW-1];
  end
  always @(negedge sck) if (!ss) begin
    s_sh   = s_sh << 1;
    s_miso = s_sh[DW-1];
  end
  always @(posedge sck) begin
    rise_cnt++;
    t_rise = $time;
    s_rx   = {s_rx[DW-2:0], mosi};
  end
  always @(posedge ss) slave_got = s_rx;
  always @(mosi) t_mosi = $time;

  // Timing model: everything is a function of cycles since the accepting edge
  int            cyc = 0, ta = 0, nd_cyc = -1, ready = 0;
  bit            active = 0, elig = 0, pend_slave = 0, nd_slave = 0;
  logic [DW-1:0] tx = '0, pend = '0, pend_tx = '0, exp_dout = '0, exp_slave = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      active   = 0;
      ready    = 0;
      nd_cyc   = -1;
      exp_dout = '0;
    end else begin
      cyc++;
      if (active && cyc - ta == T_XFER) begin
        exp_dout  = pend;
        nd_cyc    = cyc;
        nd_slave  = pend_slave;
        exp_slave = pend_tx;
      end
      if (active && cyc - ta > T_BUSY) active = 0;
      elig = (ready >= 2) && !active;
`ifdef SPI_MASTER_BURST_EN
      if (active && cyc - ta == T_XFER) elig = 1;
`endif
      if (ready < 2) ready++;
      if (elig && start) begin
        active     = 1;
        ta         = cyc;
        tx         = din;
        pend       = loop_mode ? din : slave_tx;
        pend_slave = !loop_mode;
        pend_tx    = din;
      end
    end
  end

  int k, idx;
  bit e_ss, e_busy, e_sck, e_nd;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ss", ss, 1);
      chk("rst_sck", sck, 0);
      chk("rst_busy", busy, 0);
      chk("rst_new_data", new_data, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_dout", dout, 0);
    end else begin
      k      = cyc - ta;
      e_ss   = !(active && k < T_XFER);
      e_busy = active && k < T_BUSY;
      e_sck  = active && k >= 2*C && k < 33*C && (((k - C) / C) % 2 == 1);
      e_nd   = (cyc == nd_cyc);
      chk("ss", ss, e_ss);
      chk("busy", busy, e_busy);
      chk("sck", sck, e_sck);
      chk("new_data", new_data, e_nd);
      chk("dout", dout, exp_dout);
      if (!e_ss) begin
        idx = (k < 3*C) ? DW-1 : DW-2 - (k - 3*C) / (2*C);
        if (idx < 0) idx = 0;
        chk("mosi", mosi, tx[idx]);
      end
      if (e_nd && nd_slave) chk("slave_rx", slave_got, exp_slave);
    end
    if (rise_cnt != rise_seen) begin
      rise_seen = rise_cnt;
      chk("mosi_stable_at_rise", (t_rise - t_mosi) >= C*10, 1);
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, output int cnt);
    start = 1'b1;
    din   = w;
    tick1();
    start = 1'b0;
    din   = DW'($urandom);
    cnt   = 1;
    while (!new_data && cnt < 1000) begin
      tick1();
      cnt++;
    end
    chk("new_data_seen", new_data, 1);
  endtask

  int n, c, t1, nds, nd1, nd2, ss_hi, base_r, base_f;
  logic [DW-1:0] d1, d2;

  initial begin
    rst = 1'b0;
    repeat (3) tick1();
    chk("reset_ss", ss, 1);
    chk("reset_busy", busy, 0);
    chk("reset_dout", dout, 16'h0000);
    rst = 1'b1;
    repeat (5) tick1();

    // Loopback word
    loop_mode = 1'b1;
    base_r    = rise_cnt;
    send(16'hA55A, n);
    chk("t1_latency", n, 137);
    chk("t1_dout", dout, 16'hA55A);
    chk("t1_sck_rises", rise_cnt - base_r, 16);
    tick1();
    chk("t1_new_data_single", new_data, 0);
    repeat (2*C) tick1();

    // Slave returns 1234 while master sends BEEF
    loop_mode = 1'b0;
    slave_tx  = 16'h1234;
    send(16'hBEEF, n);
    chk("t2_dout", dout, 16'h1234);
    chk("t2_slave_rx", slave_got, 16'hBEEF);
    repeat (2*C) tick1();

    // start while busy is ignored
    loop_mode = 1'b1;
    base_f    = ss_fall;
    start = 1'b1;
    din   = 16'h1357;
    tick1();
    start = 1'b0;
    n = 1;
    while (!new_data && n < 1000) begin
      tick1();
      n++;
      if (n == 20) begin
        start = 1'b1;
        din   = 16'hFFFF;
      end else if (n == 21) begin
        start = 1'b0;
      end
    end
    chk("t3_new_data_seen", new_data, 1);
    chk("t3_latency", n, 137);
    chk("t3_dout", dout, 16'h1357);
    repeat (3*C) tick1();
    chk("t3_ss_falls", ss_fall - base_f, 1);
    chk("t3_idle", busy, 0);

    // Reset at the 8th rising sck edge
    base_r = rise_cnt;
    start  = 1'b1;
    din    = 16'hC3C3;
    tick1();
    start = 1'b0;
    n = 0;
    while (rise_cnt - base_r < 8 && n < 1000) begin
      tick1();
      n++;
    end
    chk("t4_rise8", rise_cnt - base_r, 8);
    rst = 1'b0;
    #1;
    chk("t4_ss", ss, 1);
    chk("t4_sck", sck, 0);
    chk("t4_busy", busy, 0);
    chk("t4_new_data", new_data, 0);
    repeat (3) tick1();
    rst = 1'b1;
    repeat (5) tick1();
    send(16'h0F0F, n);
    chk("t4_latency", n, 137);
    chk("t4_dout", dout, 16'h0F0F);
    repeat (2*C) tick1();

    // Two words back to back
    base_f = ss_fall;
    start  = 1'b1;
    din    = 16'h0001;
    tick1();
    t1  = ta;
    din = 16'h8000;
    c = 0; nds = 0; ss_hi = 0; nd1 = 0; nd2 = 0; d1 = '0; d2 = '0;
    while (nds < 2 && c < 1000) begin
      tick1();
      c++;
      if (ta != t1) start = 1'b0;
      if (ss && !new_data && ss_fall - base_f == 1) ss_hi++;
      if (new_data) begin
        if (nds == 0) begin
          nd1 = c;
          d1  = dout;
        end else begin
          nd2 = c;
          d2  = dout;
        end
        nds++;
      end
    end
    start = 1'b0;
    chk("t5_pulses", nds, 2);
    chk("t5_word1", d1, 16'h0001);
    chk("t5_word2", d2, 16'h8000);
`ifdef SPI_MASTER_BURST_EN
    chk("t5_spacing", nd2 - nd1, 136);
    chk("t5_ss_gap", ss_hi, 0);
`else
    chk("t5_ss_gap_min", ss_hi >= C, 1);
    chk("t5_spacing_min", (nd2 - nd1) > 136, 1);
`endif
    repeat (2*C) tick1();

    // Randomized traffic, occasional resets
    repeat (4000) begin
      din   = DW'($urandom);
      start = ($urandom_range(0, 9) == 0);
      if (!active) begin
`ifndef SPI_MASTER_BURST_EN
        loop_mode = 1'($urandom_range(0, 1));
`endif
        slave_tx = DW'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b0;
        tick1();
        tick1();
        rst = 1'b1;
      end
      tick1();
    end
    start = 1'b0;
    repeat (40*C) tick1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
